// File: rtl/int_ctrl.sv
// int_ctrl: edge-capturing interrupt controller with priority select and a
// claim/complete handshake toward the core.
//   clk, rst          : clock, synchronous active-high reset
//   data_i/addr_i     : bus write data / address (addr_i[4:0] decoded)
//   we_i/req_i        : bus write enable / one-cycle access request
//   data_o            : combinational read data
//   ack_o             : registered acknowledge, one cycle after req_i
//   irq_src_i         : peripheral interrupt levels, source k has ID k+1
//   int_req_o/int_id_o: registered request and requested ID to the core
module int_ctrl #(
  parameter int unsigned NUM_SRC = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        data_i,
  input  logic [31:0]        addr_i,
  input  logic               we_i,
  input  logic               req_i,
  output logic [31:0]        data_o,
  output logic               ack_o,
  input  logic [NUM_SRC-1:0] irq_src_i,
  output logic               int_req_o,
  output logic [7:0]         int_id_o
);

  localparam int unsigned ID_W   = 8;
  localparam int unsigned ADDR_W = 5;

  localparam logic [ADDR_W-1:0] A_ENABLE   = 5'h00;
  localparam logic [ADDR_W-1:0] A_PENDING  = 5'h04;
  localparam logic [ADDR_W-1:0] A_CLAIM    = 5'h08;
  localparam logic [ADDR_W-1:0] A_COMPLETE = 5'h0C;
  localparam logic [ADDR_W-1:0] A_STATUS   = 5'h10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_SRC-1:0]  enable_q, enable_d;
  logic [NUM_SRC-1:0]  pending_q, pending_d;
  logic [NUM_SRC-1:0]  irq_prev_q, irq_prev_d;
  logic [ID_W-1:0]     active_id_q, active_id_d;
  logic                ack_q, ack_d;
  logic                int_req_q, int_req_d;
  logic [ID_W-1:0]     int_id_q, int_id_d;

  logic [ADDR_W-1:0]   addr;
  logic                wr, rd;
  logic [NUM_SRC-1:0]  rise, ep, best_oh, clr;
  logic [ID_W-1:0]     best_id;
  logic                any_ep, claim, complete_hit;
  logic                unused_bits;

  // Bus decode and pending-source selection
  assign addr    = addr_i[ADDR_W-1:0];
  assign wr      = req_i & we_i;
  assign rd      = req_i & ~we_i;
  assign rise    = irq_src_i & ~irq_prev_q;
  assign ep      = pending_q & enable_q;
  assign any_ep  = |ep;
  // Isolate lowest set bit: lowest index is highest priority
  assign best_oh = ep & (~ep + NUM_SRC'(1));
  assign claim   = rd && (addr == A_CLAIM) && (state_q == ST_ARMED) && any_ep;
  assign complete_hit = wr && (addr == A_COMPLETE) && (data_i[ID_W-1:0] == active_id_q);
  assign unused_bits  = ^{data_i, addr_i[31:ADDR_W]};

  always_comb begin
    best_id = '0;
    for (int k = int'(NUM_SRC) - 1; k >= 0; k--) begin
      if (ep[k]) best_id = ID_W'(k + 1);
    end
  end

  // Next-state logic for capture, registers and the service FSM
  always_comb begin
    state_d     = state_q;
    enable_d    = enable_q;
    active_id_d = active_id_q;
    irq_prev_d  = irq_src_i;
    ack_d       = req_i;
    int_req_d   = 1'b0;
    int_id_d    = '0;
    clr         = '0;

    if (wr && addr == A_ENABLE)  enable_d = data_i[NUM_SRC-1:0];
    if (wr && addr == A_PENDING) clr = data_i[NUM_SRC-1:0];
    if (claim)                   clr = clr | best_oh;
    // A new edge wins over any clear of the same bit
    pending_d = (pending_q & ~clr) | rise;

    case (state_q)
      ST_ARMED: begin
        if (!any_ep) begin
          state_d = ST_IDLE;
        end else if (claim) begin
          state_d     = ST_SERVICE;
          active_id_d = best_id;
        end else begin
          int_req_d = 1'b1;
          int_id_d  = best_id;
        end
      end
      ST_SERVICE: begin
        if (complete_hit) begin
          state_d     = ST_IDLE;
          active_id_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        if (any_ep) begin
          state_d   = ST_ARMED;
          int_req_d = 1'b1;
          int_id_d  = best_id;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      enable_q    <= '0;
      pending_q   <= '0;
      irq_prev_q  <= '0;
      active_id_q <= '0;
      ack_q       <= 1'b0;
      int_req_q   <= 1'b0;
      int_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      enable_q    <= enable_d;
      pending_q   <= pending_d;
      irq_prev_q  <= irq_prev_d;
      active_id_q <= active_id_d;
      ack_q       <= ack_d;
      int_req_q   <= int_req_d;
      int_id_q    <= int_id_d;
    end
  end

  // Read mux; CLAIM shows the best ID only while a claim would succeed
  always_comb begin
    data_o = '0;
    case (addr)
      A_ENABLE:  data_o = 32'(enable_q);
      A_PENDING: data_o = 32'(pending_q);
      A_CLAIM:   data_o = (state_q == ST_ARMED) ? 32'(best_id) : 32'd0;
      A_STATUS:  data_o = {16'h0, active_id_q, 6'h0, state_q};
      default:   data_o = '0;
    endcase
  end

  assign ack_o     = ack_q;
  assign int_req_o = int_req_q;
  assign int_id_o  = int_id_q;

endmodule
